axil_sram_resp: RTL and testbench

AXI4-Lite responder (slave) holding a word-addressed on-chip memory, with a configurable response latency. It is the memory-side end of the load/store channel that the CPU's memory-access stage drives. It accepts read and write transactions independently, applies byte strobes, and returns OKAY or SLVERR. It also stands in as the data-memory model for simulation.

---
 rtl/axil_sram_resp_if.sv | 36 +++
 rtl/axil_sram_resp.sv | 239 +++++++++++++++++++++++
 tb/tb_axil_sram_resp.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/axil_sram_resp_if.sv
// AXI4-Lite bus bundle between a load/store master and the SRAM responder.
// Carries the AR/R/AW/W/B channels; clk and rst stay outside as plain ports.
//   master : drives addresses, write data/strobes, valids and response readies
//   slave  : drives address/data readies, read data and responses with valids
interface axil_sram_resp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_sram_resp.sv
// AXI4-Lite responder backed by a word-addressed on-chip memory with a
// configurable response latency. Reads and writes run independently, one
// outstanding transaction each; out-of-range addresses answer SLVERR.
// Ports:
//   clk  - single clock, posedge
//   rst  - synchronous active-high reset
//   s    - axil_sram_resp_if.slave (AR/R/AW/W/B channels)
// Optional: define AXIL_SRAM_LFSR_DELAY_EN to add a pseudo-random 0..7 cycle
// extra wait per transaction from a 16-bit LFSR (seed 16'hACE1).
module axil_sram_resp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 1
) (
  input  logic              clk,
  input  logic              rst,
  axil_sram_resp_if.slave   s
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP, W_DONE} wstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Wait-cycle load value: fixed latency plus optional random extra
  logic [CNT_W-1:0] w_extra;
  logic [CNT_W-1:0] w_load;
`ifdef AXIL_SRAM_LFSR_DELAY_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_extra = CNT_W'(r_lfsr[2:0]);
`else
  assign w_extra = '0;
`endif
  assign w_load = CNT_W'(LATENCY) + w_extra;

  // Address decode for both channels
  logic [IDX_W-1:0] w_ar_idx, w_aw_idx;
  logic             w_ar_ok, w_aw_ok;
  assign w_ar_idx = s.araddr[OFF_W +: IDX_W];
  assign w_aw_idx = s.awaddr[OFF_W +: IDX_W];
  assign w_ar_ok  = (s.araddr >> OFF_W) < ADDR_WIDTH'(DEPTH);
  assign w_aw_ok  = (s.awaddr >> OFF_W) < ADDR_WIDTH'(DEPTH);

  // ---------------- read channel ----------------
  rstate_t          r_rstate, w_rnext;
  logic [CNT_W-1:0] r_rcnt, w_rcnt_next;
  logic [IDX_W-1:0] r_ar_idx, w_rd_idx;
  logic             r_ar_ok, w_rd_ok;
  logic             w_ar_fire, w_rd_mem;
  logic             r_arready, r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]       r_rresp;

  // Read next-state: memory is sampled on the edge that enters R_RESP
  always_comb begin
    w_rnext     = r_rstate;
    w_rcnt_next = r_rcnt;
    w_ar_fire   = 1'b0;
    w_rd_mem    = 1'b0;
    unique case (r_rstate)
      R_IDLE: if (s.arvalid) begin
        w_ar_fire = 1'b1;
        if (w_load == '0) begin
          w_rnext  = R_RESP;
          w_rd_mem = 1'b1;
        end else begin
          w_rnext     = R_WAIT;
          w_rcnt_next = w_load;
        end
      end
      R_WAIT: begin
        w_rcnt_next = r_rcnt - CNT_W'(1);
        if (r_rcnt <= CNT_W'(1)) begin
          w_rnext     = R_RESP;
          w_rcnt_next = '0;
          w_rd_mem    = 1'b1;
        end
      end
      R_RESP: if (s.rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Zero-latency reads use the live address, otherwise the captured one
  assign w_rd_idx = (r_rstate == R_IDLE) ? w_ar_idx : r_ar_idx;
  assign w_rd_ok  = (r_rstate == R_IDLE) ? w_ar_ok  : r_ar_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_rcnt    <= '0;
      r_ar_idx  <= '0;
      r_ar_ok   <= 1'b0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rstate  <= w_rnext;
      r_rcnt    <= w_rcnt_next;
      r_arready <= (w_rnext == R_IDLE);
      r_rvalid  <= (w_rnext == R_RESP);
      if (w_ar_fire) begin
        r_ar_idx <= w_ar_idx;
        r_ar_ok  <= w_ar_ok;
      end
      if (w_rd_mem) begin
        r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
        r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
      end
    end
  end

  // ---------------- write channel ----------------
  wstate_t          r_wstate, w_wnext;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_next;
  logic             r_aw_got, r_w_got, w_aw_got_next, w_w_got_next;
  logic             w_aw_fire, w_w_fire, w_aw_have, w_w_have, w_wr_mem;
  logic [IDX_W-1:0] r_aw_idx, w_wr_idx;
  logic             r_aw_ok, w_wr_ok;
  logic [DATA_WIDTH-1:0] r_wdata, w_wr_data;
  logic [STRB_W-1:0]     r_wstrb, w_wr_strb;
  logic             r_awready, r_wready, r_bvalid;
  logic [1:0]       r_bresp;

  assign w_aw_fire = (r_wstate == W_IDLE) && !r_aw_got && s.awvalid;
  assign w_w_fire  = (r_wstate == W_IDLE) && !r_w_got  && s.wvalid;
  assign w_aw_have = r_aw_got | w_aw_fire;
  assign w_w_have  = r_w_got  | w_w_fire;

  // Write next-state: commit happens on the edge that enters W_RESP
  always_comb begin
    w_wnext       = r_wstate;
    w_wcnt_next   = r_wcnt;
    w_aw_got_next = r_aw_got;
    w_w_got_next  = r_w_got;
    w_wr_mem      = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_aw_got_next = w_aw_have;
        w_w_got_next  = w_w_have;
        if (w_aw_have && w_w_have) begin
          if (w_load == '0) begin
            w_wnext  = W_RESP;
            w_wr_mem = 1'b1;
          end else begin
            w_wnext     = W_WAIT;
            w_wcnt_next = w_load;
          end
        end
      end
      W_WAIT: begin
        w_wcnt_next = r_wcnt - CNT_W'(1);
        if (r_wcnt <= CNT_W'(1)) begin
          w_wnext     = W_RESP;
          w_wcnt_next = '0;
          w_wr_mem    = 1'b1;
        end
      end
      W_RESP: if (s.bready) begin
        w_wnext       = W_IDLE;
        w_aw_got_next = 1'b0;
        w_w_got_next  = 1'b0;
      end
      default: begin
        w_wnext       = W_IDLE;
        w_aw_got_next = 1'b0;
        w_w_got_next  = 1'b0;
      end
    endcase
  end

  // Channels captured earlier come from registers, same-cycle ones are live
  assign w_wr_idx  = r_aw_got ? r_aw_idx : w_aw_idx;
  assign w_wr_ok   = r_aw_got ? r_aw_ok  : w_aw_ok;
  assign w_wr_data = r_w_got  ? r_wdata  : s.wdata;
  assign w_wr_strb = r_w_got  ? r_wstrb  : s.wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_wcnt    <= '0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_ok   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wnext;
      r_wcnt    <= w_wcnt_next;
      r_aw_got  <= w_aw_got_next;
      r_w_got   <= w_w_got_next;
      r_awready <= (w_wnext == W_IDLE) && !w_aw_got_next;
      r_wready  <= (w_wnext == W_IDLE) && !w_w_got_next;
      r_bvalid  <= (w_wnext == W_RESP);
      if (w_aw_fire) begin
        r_aw_idx <= w_aw_idx;
        r_aw_ok  <= w_aw_ok;
      end
      if (w_w_fire) begin
        r_wdata <= s.wdata;
        r_wstrb <= s.wstrb;
      end
      if (w_wr_mem) r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
    end
  end

  // Storage is not reset; a reset cycle suppresses any pending commit
  always_ff @(posedge clk) begin
    if (!rst && w_wr_mem && w_wr_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  assign s.arready = r_arready;
  assign s.rvalid  = r_rvalid;
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;
  assign s.awready = r_awready;
  assign s.wready  = r_wready;
  assign s.bvalid  = r_bvalid;
  assign s.bresp   = r_bresp;
endmodule

// File: tb/tb_axil_sram_resp.sv
// Bench for axil_sram_resp: directed test-plan steps followed by random
// read/write traffic, checked against a word-level memory model.
module tb_axil_sram_resp;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] mdl [int];
  logic [31:0] pool [8];

  axil_sram_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axil_sram_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >> 2) < DEPTH;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int w;
    if (!in_range(a)) return 32'h0;
    w = int'(a >> 2);
    return mdl.exists(w) ? mdl[w] : 32'h0;
  endfunction

  function automatic void mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int w;
    logic [31:0] cur;
    if (!in_range(a)) return;
    w   = int'(a >> 2);
    cur = mdl.exists(w) ? mdl[w] : 32'h0;
    for (int b = 0; b < 4; b++) if (st[b]) cur[8*b +: 8] = d[8*b +: 8];
    mdl[w] = cur;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int wlead);
    int n;
    if (wlead > 0) begin
      bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
      chk("w_wready", bus.wready, 1);
      tick;
      bus.wvalid = 1'b0; bus.wdata = $urandom;
      for (int i = 1; i < wlead; i++) begin
        chk("w_wready_drop", bus.wready, 0);
        chk("w_awready_hold", bus.awready, 1);
        tick;
      end
      chk("w_wready_drop", bus.wready, 0);
      bus.awaddr = a; bus.awvalid = 1'b1;
      chk("w_awready", bus.awready, 1);
      tick;
      bus.awvalid = 1'b0;
    end else begin
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
      chk("w_awready", bus.awready, 1);
      chk("w_wready", bus.wready, 1);
      tick;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.wdata = $urandom;
    end
    n = 1;
    while (!bus.bvalid && n < 64) begin tick; n++; end
    chk("b_latency", n, 1 + LAT);
    chk("bresp", bus.bresp, in_range(a) ? 2'b00 : 2'b10);
    mdl_wr(a, d, st);
    bus.bready = 1'b1;
    tick;
    bus.bready = 1'b0;
    chk("b_drop", bus.bvalid, 0);
    chk("w_idle_awready", bus.awready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall);
    int n;
    chk("r_arready", bus.arready, 1);
    bus.araddr = a; bus.arvalid = 1'b1;
    tick;
    bus.arvalid = 1'b0; bus.araddr = $urandom;
    n = 1;
    while (!bus.rvalid && n < 64) begin tick; n++; end
    chk("r_latency", n, 1 + LAT);
    chk("rdata", bus.rdata, exp_rd(a));
    chk("rresp", bus.rresp, in_range(a) ? 2'b00 : 2'b10);
    for (int i = 0; i < stall; i++) begin
      tick;
      chk("stall_rvalid", bus.rvalid, 1);
      chk("stall_rdata", bus.rdata, exp_rd(a));
      chk("stall_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    tick;
    bus.rready = 1'b0;
    chk("r_drop", bus.rvalid, 0);
    chk("r_next_arready", bus.arready, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    rst = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;

    // reset state
    chk("rst_arready", bus.arready, 1);
    chk("rst_awready", bus.awready, 1);
    chk("rst_wready",  bus.wready, 1);
    chk("rst_rvalid",  bus.rvalid, 0);
    chk("rst_bvalid",  bus.bvalid, 0);
    chk("rst_rdata",   bus.rdata, 0);
    chk("rst_rresp",   bus.rresp, 0);
    chk("rst_bresp",   bus.bresp, 0);

    // full write then read back, then partial byte-1 update
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_read(32'h10, 0);
    chk("plan_full", exp_rd(32'h10), 32'hDEADBEEF);
    do_write(32'h10, 32'h00005500, 4'b0010, 0);
    do_read(32'h10, 0);
    chk("plan_partial", exp_rd(32'h10), 32'hDEAD55EF);

    // zero strobe leaves the word alone
    do_write(32'h10, 32'h12345678, 4'h0, 0);
    do_read(32'h13, 0);

    // W channel three cycles ahead of AW
    do_write(32'h20, 32'hCAFEF00D, 4'hF, 3);
    do_read(32'h20, 0);

    // stalled read response
    do_read(32'h20, 5);

    // out-of-range accesses
    do_write(32'h0, 32'h0BADF00D, 4'hF, 0);
    do_read(32'h1000, 0);
    do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0);
    do_read(32'h0, 0);

    // reset while a read waits for its data
    bus.araddr = 32'h20; bus.arvalid = 1'b1;
    tick;
    bus.arvalid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstwait_rvalid", bus.rvalid, 0);
    chk("rstwait_arready", bus.arready, 1);
    tick;
    chk("rstwait_no_resp", bus.rvalid, 0);
    do_read(32'h20, 0);

    // random traffic over a small pool of initialised words
    for (int i = 0; i < 8; i++) begin
      pool[i] = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      do_write(pool[i], $urandom, 4'hF, 0);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + ($urandom & 32'h00FF_FFFF);
      else a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
